hex_key_entry: RTL and testbench

- Input-side counterpart of the seven-segment display path.
- Lets the operator type a 64-bit hex value on the DE1-SoC board: SW[3:0] gives the nibble, KEY buttons act as enter, commit and clear.
- Offers the finished word to the processor datapath over a valid/ready handshake.
- Exports the in-progress word so the display interface can show it while it is being typed.

---
 rtl/hex_key_entry_pkg.sv | 13 +
 rtl/key_debouncer.sv | 48 ++++
 rtl/hex_key_entry.sv | 116 +++++++++++
 tb/tb_hex_key_entry.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_key_entry_pkg.sv
// Shared definitions for the hex key-entry block: FSM encoding, nibble width
// and the default debounce interval.
package hex_key_entry_pkg;

  typedef enum logic {
    ENTRY = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int NIBBLE_W                = 4;

endpackage

// File: rtl/key_debouncer.sv
// Conditions one raw active-low push-button: 2-flop synchroniser, level
// debouncer and a single-cycle press pulse on a debounced 1->0 transition.
module key_debouncer
  import hex_key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // The level flips on the last of DEBOUNCE_CYCLES consecutive differing samples.
  assign flip = (sync_b != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
      press  <= flip & level;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hex_key_entry.sv
// Operator hex entry: builds a word one nibble at a time from SW/KEY and
// offers the finished word over a valid/ready handshake.
module hex_key_entry
  import hex_key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NIBBLES         = 16
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic [NIBBLE_W-1:0]               iSW,
  input  logic                              iKEY_Digit,
  input  logic                              iKEY_Commit,
  input  logic                              iKEY_Clear,
  output logic [NIBBLE_W*NIBBLES-1:0]       oPreview,
  output logic [$clog2(NIBBLES+1)-1:0]      oCount,
  output logic                              oFull,
  output logic [NIBBLE_W*NIBBLES-1:0]       oData,
  output logic                              oValid,
  input  logic                              iReady
);

  localparam int DATA_W = NIBBLE_W * NIBBLES;
  localparam int CNT_W  = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(NIBBLES);

  logic              digit_press;
  logic              commit_press;
  logic              clear_press;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] entry_buf;
  logic [DATA_W-1:0] buf_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] data_nxt;
  logic              valid;
  logic              valid_nxt;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit (
    .clk(iCLK), .rst(iRST), .key_n(iKEY_Digit), .press(digit_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
    .clk(iCLK), .rst(iRST), .key_n(iKEY_Commit), .press(commit_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(iCLK), .rst(iRST), .key_n(iKEY_Clear), .press(clear_press)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= ENTRY;
      entry_buf <= '0;
      count     <= '0;
      data      <= '0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nxt;
      entry_buf <= buf_nxt;
      count     <= count_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
    end
  end

  // Clear outranks Commit, which outranks Digit; a ready consumer wins over a Clear abort.
  always_comb begin
    state_nxt = state;
    buf_nxt   = entry_buf;
    count_nxt = count;
    data_nxt  = data;
    valid_nxt = valid;
    case (state)
      ENTRY: begin
        if (clear_press) begin
          buf_nxt   = '0;
          count_nxt = '0;
        end else if (commit_press) begin
          data_nxt  = entry_buf;
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end else if (digit_press && (count != COUNT_MAX)) begin
          buf_nxt   = {entry_buf[DATA_W-NIBBLE_W-1:0], iSW};
          count_nxt = count + CNT_W'(1);
        end else begin
          state_nxt = ENTRY;
        end
      end
      OFFER: begin
        if (iReady || clear_press) begin
          valid_nxt = 1'b0;
          buf_nxt   = '0;
          count_nxt = '0;
          state_nxt = ENTRY;
        end else begin
          state_nxt = OFFER;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = ENTRY;
      end
    endcase
  end

  assign oPreview = entry_buf;
  assign oCount   = count;
  assign oFull    = (count == COUNT_MAX);
  assign oData    = data;
  assign oValid   = valid;

endmodule

// File: tb/tb_hex_key_entry.sv
// Directed plus randomized bench for hex_key_entry, checked against a
// digit-queue reference model.
module tb_hex_key_entry;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [3:0]  iSW;
  logic        iKEY_Digit;
  logic        iKEY_Commit;
  logic        iKEY_Clear;
  logic [63:0] oPreview;
  logic [4:0]  oCount;
  logic        oFull;
  logic [63:0] oData;
  logic        oValid;
  logic        iReady;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          xfers = 0;
  logic [63:0] xfer_data = 64'd0;

  // reference model: typed digits in entry order, plus offer state
  logic [3:0]  m_q[$];
  bit          m_valid = 1'b0;
  logic [63:0] m_data  = 64'd0;
  int          m_xfers = 0;

  int          r;
  logic [3:0]  nb;

  hex_key_entry #(.DEBOUNCE_CYCLES(4), .NIBBLES(16)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSW(iSW),
    .iKEY_Digit(iKEY_Digit), .iKEY_Commit(iKEY_Commit), .iKEY_Clear(iKEY_Clear),
    .oPreview(oPreview), .oCount(oCount), .oFull(oFull),
    .oData(oData), .oValid(oValid), .iReady(iReady)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (oValid === 1'b1 && iReady === 1'b1) begin
      xfers     = xfers + 1;
      xfer_data = oData;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_preview();
    logic [63:0] v = 64'd0;
    foreach (m_q[i]) v = (v * 64'd16) + 64'(m_q[i]);
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".preview"}, oPreview, m_preview());
    check({tag, ".count"}, 64'(oCount), 64'(m_q.size()));
    check({tag, ".full"}, 64'(oFull), 64'(m_q.size() == 16));
    check({tag, ".valid"}, 64'(oValid), 64'(m_valid));
    if (m_valid) check({tag, ".data"}, oData, m_data);
    check({tag, ".xfers"}, 64'(xfers), 64'(m_xfers));
  endtask

  task automatic model_apply(input bit d, input bit c, input bit k, input logic [3:0] nib, input bit rdy);
    if (!m_valid) begin
      if (k) m_q.delete();
      else if (c) begin
        m_data  = m_preview();
        m_valid = 1'b1;
      end else if (d && m_q.size() < 16) m_q.push_back(nib);
    end else if (rdy || k) begin
      if (rdy) m_xfers++;
      m_valid = 1'b0;
      m_q.delete();
    end
  endtask

  task automatic release_keys();
    iKEY_Digit  = 1'b1;
    iKEY_Commit = 1'b1;
    iKEY_Clear  = 1'b1;
  endtask

  // Press the chosen keys together; rdy raises iReady exactly in the pulse cycle.
  task automatic press(input bit d, input bit c, input bit k, input logic [3:0] nib,
                       input bit rdy, input string tag);
    logic [63:0] exp_x;
    bit          was_valid;
    iSW         = nib;
    iKEY_Digit  = ~d;
    iKEY_Commit = ~c;
    iKEY_Clear  = ~k;
    repeat (6) tick();
    check_all({tag, ".pre"});
    if (rdy) iReady = 1'b1;
    tick();
    iReady    = 1'b0;
    exp_x     = m_data;
    was_valid = m_valid;
    model_apply(d, c, k, nib, rdy);
    check_all(tag);
    if (rdy && was_valid) check({tag, ".xdata"}, xfer_data, exp_x);
    release_keys();
    iSW = 4'($urandom_range(0, 15));
    repeat (7) tick();
    check_all({tag, ".rel"});
  endtask

  task automatic accept(input int n, input string tag);
    logic [63:0] exp_x;
    repeat (n) begin
      tick();
      check({tag, ".hold_valid"}, 64'(oValid), 64'd1);
      check({tag, ".hold_data"}, oData, m_data);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    exp_x  = m_data;
    model_apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    check_all(tag);
    check({tag, ".xdata"}, xfer_data, exp_x);
  endtask

  task automatic reset_dut(input string tag);
    iRST = 1'b1;
    tick();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = 64'd0;
    check_all(tag);
    check({tag, ".data0"}, oData, 64'd0);
    iRST = 1'b0;
  endtask

  initial begin
    iRST   = 1'b1;
    iSW    = 4'h0;
    iReady = 1'b0;
    release_keys();
    tick();
    reset_dut("reset");

    press(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, "digA");
    press(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, "dig3");
    check("a3.preview", oPreview, 64'hA3);
    check("a3.count", 64'(oCount), 64'd2);

    // bouncing contact: 2-cycle low/high segments never reach the debounce length
    iSW = 4'h7;
    for (int i = 0; i < 5; i++) begin
      iKEY_Digit = i[0];
      repeat (2) tick();
    end
    check_all("bounce.mid");
    iKEY_Digit = 1'b0;
    repeat (8) tick();
    model_apply(1'b1, 1'b0, 1'b0, 4'h7, 1'b0);
    check_all("bounce.held");
    release_keys();
    repeat (8) tick();
    check_all("bounce.rel");

    press(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "clear");
    press(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "commit_empty");
    accept(0, "xfer_empty");

    for (int i = 0; i < 17; i++) press(1'b1, 1'b0, 1'b0, (i < 16) ? 4'(i) : 4'h1, 1'b0, "fill");
    check("fill.preview", oPreview, 64'h0123456789ABCDEF);
    check("fill.full", 64'(oFull), 64'd1);
    press(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "commit_full");
    accept(5, "xfer_full");

    press(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, "d5");
    press(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "commit_abort");
    press(1'b1, 1'b1, 1'b0, 4'h9, 1'b0, "offer_ignore");
    press(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "abort");

    press(1'b1, 1'b0, 1'b0, 4'hC, 1'b0, "dC");
    press(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "commit_clr_rdy");
    press(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "clr_rdy");

    press(1'b1, 1'b0, 1'b0, 4'hE, 1'b0, "dE");
    press(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, "commit_and_clear");

    press(1'b1, 1'b0, 1'b0, 4'h2, 1'b0, "d2");
    press(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "commit_rst");
    reset_dut("rst_offer");

    for (int it = 0; it < 40; it++) begin
      r  = int'($urandom_range(0, 9));
      nb = 4'($urandom_range(0, 15));
      case (r)
        0, 1, 2, 3, 4, 5: press(1'b1, 1'b0, 1'b0, nb, 1'b0, "rnd_dig");
        6:                press(1'b0, 1'b0, 1'b1, nb, 1'b0, "rnd_clr");
        7:                press(1'b0, 1'b1, 1'b0, nb, 1'b0, "rnd_commit");
        8:                press(1'b1, 1'b1, 1'b0, nb, 1'b0, "rnd_dc");
        default:          press(1'b1, 1'b1, 1'b1, nb, 1'b0, "rnd_all");
      endcase
      if (m_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          press(1'b0, 1'b0, 1'b1, nb, 1'b0, "rnd_abort");
        end else begin
          press(1'b1, 1'b1, 1'b0, nb, 1'b0, "rnd_offer_ignore");
          accept(int'($urandom_range(0, 4)), "rnd_xfer");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
